// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI command master.
package spi_pkg;

    localparam int unsigned SPI_WORD_BITS = 32;
    localparam int unsigned SPI_NUM_SS    = 16;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        HOLD,
        GAP
    } spi_state_e;

endpackage

// File: rtl/spi_cmd_master_if.sv
// Command/SPI signal bundle for spi_cmd_master; master modport is the DUT side.
interface spi_cmd_master_if;
    import spi_pkg::*;

    logic [SPI_WORD_BITS-1:0] command;
    logic [SPI_NUM_SS-1:0]    ss;
    logic                     trigger;
    logic                     ready;
    logic                     sclk;
    logic                     mosi;
    logic                     miso;
    logic [SPI_NUM_SS-1:0]    cs_n;
    logic [SPI_WORD_BITS-1:0] rdata;
    logic                     rdata_valid;

    modport master (
        input  command, ss, trigger, miso,
        output ready, sclk, mosi, cs_n, rdata, rdata_valid
    );

    modport slave (
        output command, ss, trigger, miso,
        input  ready, sclk, mosi, cs_n, rdata, rdata_valid
    );

endinterface

// File: rtl/spi_clk_div.sv
// Phase tick generator: tick_o pulses every CLK_DIV cycles; restart_i holds the count at zero.
module spi_clk_div #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic restart_i,
    output logic tick_o
);

    localparam logic [15:0] LastCnt = 16'(CLK_DIV - 1);

    logic [15:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q + 16'd1;
        if (restart_i || (cnt_q == LastCnt)) begin
            cnt_d = '0;
        end
    end

    assign tick_o = !restart_i && (cnt_q == LastCnt);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/spi_cmd_master.sv
// SPI mode-0 command master: 32-bit MSB-first word to the selected slaves.
// Optional miso readback is enabled by defining SPI_READBACK_EN.
module spi_cmd_master
    import spi_pkg::*;
#(
    parameter int unsigned CLK_DIV = 4
) (
    input logic              clock,
    input logic              reset,
    spi_cmd_master_if.master bus
);

    localparam logic [5:0] LastBit = 6'(SPI_WORD_BITS - 1);

    spi_state_e               state_q, state_d;
    logic [5:0]               bit_q, bit_d;
    logic                     half_q, half_d;
    logic [SPI_WORD_BITS-2:0] tx_q, tx_d;
    logic                     sclk_q, sclk_d;
    logic                     mosi_q, mosi_d;
    logic                     ready_q, ready_d;
    logic [SPI_NUM_SS-1:0]    cs_n_q, cs_n_d;
    logic                     tick, restart, last_bit, sample, capture;

    assign restart  = (state_q == IDLE);
    assign last_bit = (bit_q == LastBit);

    spi_clk_div #(
        .CLK_DIV(CLK_DIV)
    ) u_clk_div (
        .clock    (clock),
        .reset    (reset),
        .restart_i(restart),
        .tick_o   (tick)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            bit_q   <= '0;
            half_q  <= 1'b0;
            tx_q    <= '0;
            sclk_q  <= 1'b0;
            mosi_q  <= 1'b0;
            ready_q <= 1'b1;
            cs_n_q  <= '1;
        end else begin
            state_q <= state_d;
            bit_q   <= bit_d;
            half_q  <= half_d;
            tx_q    <= tx_d;
            sclk_q  <= sclk_d;
            mosi_q  <= mosi_d;
            ready_q <= ready_d;
            cs_n_q  <= cs_n_d;
        end
    end

    always_comb begin
        state_d = state_q;
        bit_d   = bit_q;
        half_d  = half_q;
        unique case (state_q)
            IDLE: begin
                bit_d  = '0;
                half_d = 1'b0;
                if (bus.trigger) state_d = SETUP;
            end
            SETUP: if (tick) state_d = SHIFT;
            SHIFT: begin
                if (tick) begin
                    half_d = !half_q;
                    if (half_q) begin
                        if (last_bit) state_d = HOLD;
                        else          bit_d   = bit_q + 6'd1;
                    end
                end
            end
            HOLD: if (tick) state_d = GAP;
            GAP:  if (tick) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Registered-output next values; sclk edges coincide with miso sample / mosi update.
    always_comb begin
        sclk_d  = sclk_q;
        mosi_d  = mosi_q;
        ready_d = ready_q;
        cs_n_d  = cs_n_q;
        tx_d    = tx_q;
        sample  = 1'b0;
        capture = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.trigger) begin
                    ready_d = 1'b0;
                    cs_n_d  = ~bus.ss;
                    tx_d    = bus.command[SPI_WORD_BITS-2:0];
                    mosi_d  = bus.command[SPI_WORD_BITS-1];
                end
            end
            SETUP: begin
                if (tick) begin
                    sclk_d = 1'b1;
                    sample = 1'b1;
                end
            end
            SHIFT: begin
                if (tick) begin
                    if (!half_q) begin
                        sclk_d = 1'b0;
                        if (!last_bit) begin
                            mosi_d = tx_q[SPI_WORD_BITS-2];
                            tx_d   = {tx_q[SPI_WORD_BITS-3:0], 1'b0};
                        end
                    end else if (!last_bit) begin
                        sclk_d = 1'b1;
                        sample = 1'b1;
                    end
                end
            end
            HOLD: begin
                if (tick) begin
                    cs_n_d  = '1;
                    mosi_d  = 1'b0;
                    capture = 1'b1;
                end
            end
            GAP: if (tick) ready_d = 1'b1;
            default: ;
        endcase
    end

    assign bus.ready = ready_q;
    assign bus.sclk  = sclk_q;
    assign bus.mosi  = mosi_q;
    assign bus.cs_n  = cs_n_q;

`ifdef SPI_READBACK_EN
    logic [SPI_WORD_BITS-1:0] rx_q, rdata_q;
    logic                     rdata_valid_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rx_q          <= '0;
            rdata_q       <= '0;
            rdata_valid_q <= 1'b0;
        end else begin
            if (sample)  rx_q    <= {rx_q[SPI_WORD_BITS-2:0], bus.miso};
            if (capture) rdata_q <= rx_q;
            rdata_valid_q <= capture;
        end
    end

    assign bus.rdata       = rdata_q;
    assign bus.rdata_valid = rdata_valid_q;
`else
    logic unused_rb;
    assign unused_rb       = ^{bus.miso, sample, capture};
    assign bus.rdata       = '0;
    assign bus.rdata_valid = 1'b0;
`endif

endmodule

// File: tb/tb_spi_cmd_master.sv
// Directed bench: a CLK_DIV=2 instance with a mode-0 slave model and a CLK_DIV=1 instance.
module tb_spi_cmd_master;

    logic clock = 1'b0;
    logic rst2  = 1'b0;
    logic rst1  = 1'b0;

    always #5 clock = ~clock;

    spi_cmd_master_if if2 ();
    spi_cmd_master_if if1 ();

    spi_cmd_master #(.CLK_DIV(2)) dut2 (.clock(clock), .reset(rst2), .bus(if2.master));
    spi_cmd_master #(.CLK_DIV(1)) dut1 (.clock(clock), .reset(rst1), .bus(if1.master));

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    // DUT2 observer and slave; counters are cleared when clr_gen2 changes.
    int          clr_gen2 = 0, seen_gen2 = 0;
    int          low2 = 0, sclk2 = 0, csact2 = 0, vcnt2 = 0, vat2 = 0, txn2 = 0, sidx2 = 0;
    logic [31:0] mosiw2 = '0, pat2 = '0;
    logic [15:0] csval2 = 16'hFFFF;
    logic        sclk_p2 = 1'b0, ready_p2 = 1'b1, cs_p2 = 1'b0;

    always @(negedge clock) begin
        if (seen_gen2 != clr_gen2) begin
            seen_gen2 = clr_gen2;
            low2 = 0; sclk2 = 0; csact2 = 0; vcnt2 = 0; vat2 = 0; txn2 = 0;
            mosiw2 = '0; csval2 = 16'hFFFF;
        end
        if (!if2.ready) low2++;
        if (ready_p2 && !if2.ready) txn2++;
        if (if2.sclk && !sclk_p2) begin
            sclk2++;
            mosiw2 = {mosiw2[30:0], if2.mosi};
        end
        if (if2.cs_n != 16'hFFFF) begin
            csact2++;
            csval2 = if2.cs_n;
        end
        if (if2.rdata_valid) begin
            vcnt2++;
            vat2 = low2;
        end
        if (if2.cs_n == 16'hFFFF) begin
            if2.miso = 1'b0;
        end else if (!cs_p2) begin
            if2.miso = pat2[31];
            sidx2 = 30;
        end else if (sclk_p2 && !if2.sclk && sidx2 >= 0) begin
            if2.miso = pat2[sidx2];
            sidx2--;
        end
        sclk_p2  = if2.sclk;
        ready_p2 = if2.ready;
        cs_p2    = (if2.cs_n != 16'hFFFF);
    end

    // DUT1 observer: ready low/high run lengths between transactions.
    int   clr_gen1 = 0, seen_gen1 = 0;
    int   low1 = 0, sclk1 = 0, csact1 = 0, lrun1 = 0, hrun1 = 0, nlow1 = 0;
    int   lmin1 = 999, lmax1 = 0, hmin1 = 999, hmax1 = 0;
    logic seen_low1 = 1'b0, ready_p1 = 1'b1, sclk_p1 = 1'b0;

    always @(negedge clock) begin
        if (seen_gen1 != clr_gen1) begin
            seen_gen1 = clr_gen1;
            low1 = 0; sclk1 = 0; csact1 = 0; lrun1 = 0; hrun1 = 0; nlow1 = 0;
            lmin1 = 999; lmax1 = 0; hmin1 = 999; hmax1 = 0;
            seen_low1 = 1'b0; ready_p1 = 1'b1;
        end
        if (if1.sclk && !sclk_p1) sclk1++;
        if (if1.cs_n != 16'hFFFF) csact1++;
        if (if1.ready) begin
            if (!ready_p1 && seen_low1) begin
                nlow1++;
                if (lrun1 < lmin1) lmin1 = lrun1;
                if (lrun1 > lmax1) lmax1 = lrun1;
            end
            hrun1++;
        end else begin
            if (ready_p1) begin
                if (seen_low1) begin
                    if (hrun1 < hmin1) hmin1 = hrun1;
                    if (hrun1 > hmax1) hmax1 = hrun1;
                end
                hrun1 = 0;
                lrun1 = 0;
                seen_low1 = 1'b1;
            end
            lrun1++;
            low1++;
        end
        sclk_p1  = if1.sclk;
        ready_p1 = if1.ready;
    end

    typedef struct {
        logic [31:0] cmd;
        logic [15:0] ss;
        logic [31:0] pat;
        logic [15:0] exp_cs;
        int          exp_csact;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t vecs[4];

    task automatic start_txn2(input logic [31:0] cmd, input logic [15:0] ss, input logic [31:0] pat);
        clr_gen2++;
        pat2 = pat;
        @(negedge clock);
        @(negedge clock);
        if2.command = cmd;
        if2.ss      = ss;
        if2.trigger = 1'b1;
        @(negedge clock);
        if2.trigger = 1'b0;
    endtask

    task automatic wait_idle2(input string tag);
        for (int i = 0; i < 400; i++) begin
            if (if2.ready) break;
            @(negedge clock);
        end
        check({tag, "_done"}, 32'(if2.ready), 32'd1);
        @(negedge clock);
        @(negedge clock);
    endtask

    task automatic check_txn2(input vec_t v, input string tag);
        check({tag, "_cs"},    32'(csval2), 32'(v.exp_cs));
        check({tag, "_csact"}, 32'(csact2), 32'(v.exp_csact));
        check({tag, "_sclk"},  32'(sclk2),  32'd32);
        check({tag, "_mosi"},  mosiw2,      v.cmd);
        check({tag, "_rlow"},  32'(low2),   32'd134);
        check({tag, "_ntxn"},  32'(txn2),   32'd1);
        check({tag, "_mosi0"}, 32'(if2.mosi), 32'd0);
        check({tag, "_sclk0"}, 32'(if2.sclk), 32'd0);
`ifdef SPI_READBACK_EN
        check({tag, "_rdata"}, if2.rdata,   v.exp_rd);
        check({tag, "_nval"},  32'(vcnt2),  32'd1);
        check({tag, "_valat"}, 32'(vat2),   32'd133);
`else
        check({tag, "_rdata"}, if2.rdata,   32'd0);
        check({tag, "_nval"},  32'(vcnt2),  32'd0);
`endif
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{32'h0000_2600, 16'h0002, 32'hA5C3_0F1E, 16'hFFFD, 132, 32'hA5C3_0F1E};
        vecs[1] = '{32'hFFFF_FFFF, 16'h8001, 32'h0000_0001, 16'h7FFE, 132, 32'h0000_0001};
        vecs[2] = '{32'h8000_0001, 16'hFFFF, 32'h1234_5678, 16'h0000, 132, 32'h1234_5678};
        vecs[3] = '{32'h5A5A_F00F, 16'h0000, 32'hFFFF_FFFF, 16'hFFFF, 0,   32'h0000_0000};

        if2.command = '0; if2.ss = '0; if2.trigger = 1'b0;
        if1.command = '0; if1.ss = '0; if1.trigger = 1'b0; if1.miso = 1'b0;

        #1;
        rst2 = 1'b1;
        rst1 = 1'b1;
        #3;
        check("rst_ready",  32'(if2.ready), 32'd1);
        check("rst_cs_n",   32'(if2.cs_n),  32'hFFFF);
        check("rst_sclk",   32'(if2.sclk),  32'd0);
        check("rst_mosi",   32'(if2.mosi),  32'd0);
        check("rst_rdata",  if2.rdata,      32'd0);
        check("rst_rvalid", 32'(if2.rdata_valid), 32'd0);
        check("rst_ready1", 32'(if1.ready), 32'd1);
        check("rst_cs_n1",  32'(if1.cs_n),  32'hFFFF);
        @(negedge clock);
        rst2 = 1'b0;
        rst1 = 1'b0;

        foreach (vecs[k]) begin
            start_txn2(vecs[k].cmd, vecs[k].ss, vecs[k].pat);
            wait_idle2($sformatf("vec%0d", k));
            check_txn2(vecs[k], $sformatf("vec%0d", k));
        end

        // Trigger held and inputs scrambled during a transfer.
        clr_gen2++;
        pat2 = 32'h0F0F_3C3C;
        @(negedge clock);
        @(negedge clock);
        if2.command = 32'hDEAD_BEEF;
        if2.ss      = 16'h0010;
        if2.trigger = 1'b1;
        for (int i = 0; i < 400; i++) begin
            @(negedge clock);
            if (if2.ready) break;
            if2.command = $urandom;
            if2.ss      = 16'($urandom);
        end
        if2.trigger = 1'b0;
        wait_idle2("busytrig");
        check_txn2('{32'hDEAD_BEEF, 16'h0010, 32'h0F0F_3C3C, 16'hFFEF, 132, 32'h0F0F_3C3C},
                   "busytrig");

        // Asynchronous reset during bit 10 of SHIFT.
        start_txn2(32'h1357_9BDF, 16'h0004, 32'hFFFF_0000);
        for (int i = 0; i < 200 && sclk2 < 11; i++) @(negedge clock);
        check("abort_bit", 32'(sclk2), 32'd11);
        #2;
        rst2 = 1'b1;
        #1;
        check("abort_cs_n",  32'(if2.cs_n),  32'hFFFF);
        check("abort_sclk",  32'(if2.sclk),  32'd0);
        check("abort_ready", 32'(if2.ready), 32'd1);
        check("abort_mosi",  32'(if2.mosi),  32'd0);
        #1;
        rst2 = 1'b0;
        repeat (150) @(negedge clock);
        check("abort_nval",   32'(vcnt2),     32'd0);
        check("abort_rdata",  if2.rdata,      32'd0);
        check("abort_idle",   32'(if2.ready), 32'd1);
        start_txn2(vecs[0].cmd, vecs[0].ss, vecs[0].pat);
        wait_idle2("after_rst");
        check_txn2(vecs[0], "after_rst");

        // CLK_DIV=1 dummy transfer with no slave selected.
        clr_gen1++;
        @(negedge clock);
        @(negedge clock);
        if1.command = 32'hC0DE_0001;
        if1.ss      = 16'h0000;
        if1.trigger = 1'b1;
        @(negedge clock);
        if1.trigger = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (if1.ready) break;
            @(negedge clock);
        end
        @(negedge clock);
        @(negedge clock);
        check("dummy_rlow",  32'(low1),   32'd67);
        check("dummy_sclk",  32'(sclk1),  32'd32);
        check("dummy_csact", 32'(csact1), 32'd0);
        check("dummy_ntxn",  32'(nlow1),  32'd1);

        // CLK_DIV=1 back-to-back with trigger held high.
        clr_gen1++;
        @(negedge clock);
        @(negedge clock);
        if1.command = 32'h8421_1248;
        if1.ss      = 16'h0003;
        if1.trigger = 1'b1;
        for (int i = 0; i < 1000 && nlow1 < 3; i++) @(negedge clock);
        if1.trigger = 1'b0;
        check("b2b_count", 32'(nlow1 >= 3), 32'd1);
        for (int i = 0; i < 200; i++) begin
            if (if1.ready) break;
            @(negedge clock);
        end
        @(negedge clock);
        @(negedge clock);
        check("b2b_lowmin",  32'(lmin1), 32'd67);
        check("b2b_lowmax",  32'(lmax1), 32'd67);
        check("b2b_highmin", 32'(hmin1), 32'd1);
        check("b2b_highmax", 32'(hmax1), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
